axi_lite_cmd_master: RTL

//  Single-outstanding AXI-Lite master that turns a simple valid/ready command (read or write) into one AXI-Lite transaction.

---
 rtl/axi_lite_cmd_master.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI-Lite master: one valid/ready command becomes one AXI-Lite read or write.
// Optional response timeout and idle stray-beat drain are enabled with AXIL_MST_TIMEOUT_EN.
module axi_lite_cmd_master #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic              busy,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [DATA_W-1:0] m_axi_wdata,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic              m_axi_bvalid,
  input  logic [1:0]        m_axi_bresp,
  output logic              m_axi_bready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic              m_axi_rvalid,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  output logic              m_axi_rready
);

  // state   | meaning
  // IDLE    | waiting for a command, cmd_ready high
  // WR      | AW and W beats outstanding, each valid drops after its own handshake
  // WR_RESP | waiting for B, bready high
  // RD      | AR beat outstanding
  // RD_DATA | waiting for R, rready high
  // RSP     | response held on rsp_* until rsp_ready
  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD, RD_DATA, RSP} state_t;

  state_t state;
  logic   tmo_hit;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 2");
  end

`ifdef AXIL_MST_TIMEOUT_EN
  localparam int               TMO_W      = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LOAD   = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic             IDLE_DRAIN = 1'b1;

  logic [TMO_W-1:0] tmo_cnt;

  // Reloaded outside the waiting states, so every entry into WR_RESP/RD_DATA starts a full window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= TMO_LOAD;
    end else if (state != WR_RESP && state != RD_DATA) begin
      tmo_cnt <= TMO_LOAD;
    end else if (tmo_cnt != '0) begin
      tmo_cnt <= tmo_cnt - 1'b1;
    end
  end

  assign tmo_hit = (tmo_cnt == '0);
`else
  localparam logic IDLE_DRAIN = 1'b0;

  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cmd_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= 2'b00;
      busy          <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          cmd_ready    <= 1'b1;
          m_axi_bready <= IDLE_DRAIN;
          m_axi_rready <= IDLE_DRAIN;
          if (cmd_valid && cmd_ready) begin
            cmd_ready    <= 1'b0;
            busy         <= 1'b1;
            m_axi_bready <= 1'b0;
            m_axi_rready <= 1'b0;
            if (cmd_write) begin
              m_axi_awaddr  <= cmd_addr;
              m_axi_wdata   <= cmd_wdata;
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              state         <= WR;
            end else begin
              m_axi_araddr  <= cmd_addr;
              m_axi_arvalid <= 1'b1;
              state         <= RD;
            end
          end
        end
        WR: begin
          if (m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
          // A low valid here means that channel already completed on an earlier edge.
          if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
            m_axi_bready <= 1'b1;
            state        <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (m_axi_bvalid) begin
            rsp_resp     <= m_axi_bresp;
            rsp_rdata    <= '0;
            rsp_valid    <= 1'b1;
            m_axi_bready <= 1'b0;
            state        <= RSP;
          end else if (tmo_hit) begin
            rsp_resp     <= 2'b11;
            rsp_rdata    <= '0;
            rsp_valid    <= 1'b1;
            m_axi_bready <= 1'b0;
            state        <= RSP;
          end
        end
        RD: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (m_axi_rvalid) begin
            rsp_resp     <= m_axi_rresp;
            rsp_rdata    <= m_axi_rdata;
            rsp_valid    <= 1'b1;
            m_axi_rready <= 1'b0;
            state        <= RSP;
          end else if (tmo_hit) begin
            rsp_resp     <= 2'b11;
            rsp_rdata    <= '0;
            rsp_valid    <= 1'b1;
            m_axi_rready <= 1'b0;
            state        <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid    <= 1'b0;
            cmd_ready    <= 1'b1;
            busy         <= 1'b0;
            m_axi_bready <= IDLE_DRAIN;
            m_axi_rready <= IDLE_DRAIN;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
